// File: rtl/state_dump_unit.sv
// rtl/state_dump_unit.sv - halt-triggered register-file and data-memory dump streamer
// Optional DUMP_SKIP_ZERO_EN: suppress zero-valued memory beats except the final word.
module state_dump_unit #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_tag,
    output logic [31:0] out_index,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = $clog2(MEM_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RF,
        S_DUMP_MEM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [4:0]      r_rf_cnt;
    logic [CW-1:0]   r_mem_cnt;
    logic            r_out_valid;
    logic            r_out_tag;
    logic            r_out_last;
    logic [31:0]     r_out_index;
    logic [31:0]     r_out_data;
    logic            w_load;
    logic            w_mem_last;
    logic            w_skip;
    logic [31:0]     w_mem_addr;

    // The output register is refilled whenever it is empty or being drained this cycle.
    assign w_load     = !r_out_valid || out_ready;
    assign w_mem_last = (r_mem_cnt == CW'(MEM_WORDS - 1));
    assign w_mem_addr = MEM_BASE + (32'(r_mem_cnt) << 2);

`ifdef DUMP_SKIP_ZERO_EN
    assign w_skip = (mem_data == 32'h0) && !w_mem_last;
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (halt) w_next = S_DUMP_RF;
            S_DUMP_RF:  if (w_load && (r_rf_cnt == 5'd31)) w_next = S_DUMP_MEM;
            S_DUMP_MEM: if (w_load && w_mem_last) w_next = S_FLUSH;
            S_FLUSH:    if (r_out_valid && out_ready) w_next = S_DONE;
            S_DONE:     w_next = S_DONE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_cnt    <= 5'd0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_index <= 32'h0;
            r_out_data  <= 32'h0;
        end else begin
            unique case (r_state)
                S_DUMP_RF: begin
                    if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_tag   <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_index <= {27'h0, r_rf_cnt};
                        r_out_data  <= rf_data;
                        r_rf_cnt    <= r_rf_cnt + 5'd1;
                    end
                end
                S_DUMP_MEM: begin
                    if (w_load) begin
                        r_mem_cnt <= r_mem_cnt + 1'b1;
                        if (w_skip) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_tag   <= 1'b1;
                            r_out_last  <= w_mem_last;
                            r_out_index <= w_mem_addr;
                            r_out_data  <= mem_data;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_addr   = (r_state == S_DUMP_RF)  ? r_rf_cnt   : 5'd0;
    assign mem_addr  = (r_state == S_DUMP_MEM) ? w_mem_addr : MEM_BASE;
    assign out_valid = r_out_valid;
    assign out_tag   = r_out_tag;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state == S_DUMP_RF) || (r_state == S_DUMP_MEM) || (r_state == S_FLUSH);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_state_dump_unit.sv
// tb/tb_state_dump_unit.sv - directed self-checking bench for state_dump_unit (MEM_WORDS=4)
module tb_state_dump_unit;

    logic        clk;
    logic        rst;
    logic        halt;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_tag;
    logic [31:0] out_index;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [4];
    logic [65:0] exp_q [$];
    int          n_checks;
    int          n_fail;

    state_dump_unit #(.MEM_WORDS(4), .MEM_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_index(out_index), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign rf_data  = {8'hA5, 3'b000, rf_addr, 11'h000, rf_addr};
    assign mem_data = mem[mem_addr[3:2]];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_exp();
        bit skip_en;
`ifdef DUMP_SKIP_ZERO_EN
        skip_en = 1'b1;
`else
        skip_en = 1'b0;
`endif
        exp_q.delete();
        for (int r = 0; r < 32; r++) begin
            logic [4:0] r5;
            r5 = 5'(r);
            exp_q.push_back({1'b0, 1'b0, 32'(r), {8'hA5, 3'b000, r5, 11'h000, r5}});
        end
        for (int i = 0; i < 4; i++) begin
            if (!(skip_en && mem[i] == 32'h0 && i != 3))
                exp_q.push_back({1'b1, (i == 3), 32'(4 * i), mem[i]});
        end
    endtask

    // Starts a dump at the next edge and follows it to DONE, scoring every accepted beat.
    task automatic run_dump(input bit stall, input bit hold, input int exp_done);
        int          k;
        int          done_edge;
        bit          was_stall;
        logic [65:0] snap;
        logic [65:0] cur;
        build_exp();
        k = 0;
        done_edge = -1;
        was_stall = 1'b0;
        snap = '0;
        halt = 1'b1;
        @(negedge clk);
        if (!hold) halt = 1'b0;
        check("busy_start", busy, 1);
        check("rf_addr_start", rf_addr, 0);
        for (int e = 0; e < 200; e++) begin
            if (done) begin
                done_edge = e;
                break;
            end
            out_ready = 1'b1;
            if (stall && e >= 4 && e < 20)
                out_ready = ((e % 4) == 0) || ((e % 4) == 3);
            cur = {out_tag, out_last, out_index, out_data};
            if (was_stall) check("stall_hold", {out_valid, cur}, {1'b1, snap});
            was_stall = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (k < exp_q.size()) check($sformatf("beat%0d", k), cur, exp_q[k]);
                    else check("extra_beat", k, exp_q.size());
                    k++;
                end else begin
                    snap = cur;
                    was_stall = 1'b1;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("beat_count", k, exp_q.size());
        check("done_edge", done_edge, exp_done);
        check("busy_end", busy, 0);
    endtask

    initial begin
        int accepted;
        n_checks  = 0;
        n_fail    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        halt      = 1'b0;
        out_ready = 1'b1;
        mem       = '{32'h0, 32'h5, 32'h0, 32'h0};
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_outs", {out_tag, out_last, out_index, out_data}, 66'h0);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_addrs", {rf_addr, mem_addr}, 37'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run_dump(1'b0, 1'b0, 37);
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_done_valid", out_valid, 0);
            check("post_done_done", done, 1);
        end
        halt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        mem = '{32'hDEAD_BEEF, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF};
        run_dump(1'b1, 1'b0, 45);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        accepted = 0;
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int e = 0; e < 50 && accepted < 10; e++) begin
            if (out_valid) accepted++;
            @(negedge clk);
        end
        check("mid_accepted", accepted, 10);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_outs", {out_index, out_data, done}, 65'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mem = '{32'h0000_0001, 32'h8000_0000, 32'h0, 32'h0};
        run_dump(1'b0, 1'b1, 37);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 0);
            check("hold_done", done, 1);
        end
        halt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/state_dump_unit.md
STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit data-memory words dumped (range 2..65536).
REQ-002 SHALL have parameter MEM_BASE, default 32'h0000_0000, byte address of the first dumped data word (word aligned).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 halt  input  1  CPU halt indication; level sensitive.
REQ-006 rf_addr  output  5  register-file read index.
REQ-007 rf_data  input  32  register-file read data, combinational from rf_addr.
REQ-008 mem_addr  output  32  data-memory byte read address, always word aligned.
REQ-009 mem_data  input  32  data-memory read data, combinational from mem_addr.
REQ-010 out_valid  output  1  output beat present.
REQ-011 out_ready  input  1  sink accepts the beat this cycle.
REQ-012 out_tag  output  1  0 = register beat, 1 = memory beat.
REQ-013 out_index  output  32  register number (tag 0) or memory byte address (tag 1).
REQ-014 out_data  output  32  dumped value.
REQ-015 out_last  output  1  final beat of the dump.
REQ-016 busy  output  1  dump in progress.
REQ-017 done  output  1  dump complete; sticky until reset.

Function
REQ-018 SHALL implement states IDLE, DUMP_RF, DUMP_MEM, FLUSH, DONE.
REQ-019 IDLE -> DUMP_RF on the first rising edge with halt=1; halt is otherwise ignored, including deassertion mid-dump.
REQ-020 DUMP_RF SHALL read x0..x31 in ascending order, then enter DUMP_MEM.
REQ-021 DUMP_MEM SHALL read MEM_BASE + 4*i for i = 0..MEM_WORDS-1 ascending, then enter FLUSH.
REQ-022 FLUSH -> DONE when the final beat is accepted.
REQ-023 Read data SHALL be captured into the output register in the same edge its address is presented (one-cycle latency from address to out_valid).
REQ-024 A new word SHALL be captured only when out_valid=0 or (out_valid=1 and out_ready=1); the read counter advances only on capture.
REQ-025 While out_valid=1 and out_ready=0, out_tag/out_index/out_data/out_last SHALL hold stable.
REQ-026 With out_ready held at 1, throughput SHALL be one beat per cycle; a full dump of 32+MEM_WORDS beats completes in 33+MEM_WORDS cycles after the halt edge.
REQ-027 out_last SHALL be 1 only on the beat for memory word MEM_WORDS-1.
REQ-028 busy SHALL be 1 in DUMP_RF, DUMP_MEM, FLUSH; done SHALL be 1 only in DONE.
REQ-029 The memory index counter SHALL be wide enough for MEM_WORDS without wrap; mem_addr arithmetic is modulo 2^32.
REQ-030 rf_addr and mem_addr SHALL be 0 and MEM_BASE respectively outside their dump states.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, out_valid=0, out_last=0, out_tag=0, out_index=0, out_data=0, busy=0, done=0, counters=0.
REQ-032 rst asserted mid-dump SHALL abandon the dump; a later halt starts a fresh dump from x0.

Configuration
REQ-033 Macro DUMP_SKIP_ZERO_EN: when defined, memory words equal to 32'h0 SHALL NOT be emitted (counter still advances, no capture cycle consumed beyond one per word); register beats and memory word MEM_WORDS-1 are always emitted.
REQ-034 Without DUMP_SKIP_ZERO_EN, every memory word SHALL be emitted.

Verification
REQ-035 MEM_WORDS=4, halt pulse one cycle, out_ready=1 -> 36 beats: x0..x31 (tag 0), then addresses 0,4,8,12 (tag 1); out_last on address 12; done=1 at cycle 37.
REQ-036 out_ready toggled 1,0,0,1 during register beats -> no beat lost or duplicated; data stable while stalled; sequence identical to REQ-035.
REQ-037 rst pulsed after 10 accepted beats -> out_valid=0, busy=0 at once; new halt restarts at x0 with index 0.
REQ-038 With DUMP_SKIP_ZERO_EN, memory contents {0,5,0,0} -> memory beats only at addresses 4 and 12; address 12 carries data 0 and out_last=1.
REQ-039 halt held high through and after dump -> exactly one dump; done stays 1, no further beats.
